// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending-write counters,
// issue qualification (flush/freeze), sticky writeback error and a
// saturating stall performance counter.
module id_hazard_scoreboard #(
   parameter int unsigned NREG      = 16,
   parameter int unsigned CNT_W     = 2,
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned STALL_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [3:0]         id_src1,
   input  logic               id_src1_vld,
   input  logic [3:0]         id_src2,
   input  logic               id_src2_vld,
   input  logic               id_wb_en,
   input  logic [3:0]         id_dest,
   input  logic               flush,
   input  logic               freeze,
   input  logic               wb_en,
   input  logic [3:0]         wb_dest,
   output logic               hazard,
   output logic               issue,
   output logic               busy,
   output logic               sb_err,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam int unsigned IDX_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]   cnt_q [NREG];
   logic [CNT_W-1:0]   cnt_d [NREG];
   logic               sb_err_q, sb_err_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [CNT_W-1:0]   src1_cnt, src2_cnt, dest_cnt;
   logic               pend1, pend2, full;
   logic [NREG-1:0]    inc_v, dec_v;

   // Pending test per source (with same-cycle writeback bypass), full check, hazard/issue
   always_comb begin
      src1_cnt = cnt_q[id_src1];
      src2_cnt = cnt_q[id_src2];
      dest_cnt = cnt_q[id_dest];
      pend1 = (src1_cnt != '0) &&
              !(WB_BYPASS && wb_en && (wb_dest == id_src1) && (src1_cnt == CNT_ONE));
      pend2 = (src2_cnt != '0) &&
              !(WB_BYPASS && wb_en && (wb_dest == id_src2) && (src2_cnt == CNT_ONE));
      full   = id_wb_en && (dest_cnt == CNT_MAX);
      hazard = id_valid && !flush &&
               ((id_src1_vld && pend1) || (id_src2_vld && pend2) || full);
      issue  = id_valid && !hazard && !flush && !freeze;
   end

   // Next-state of the per-register counters; a simultaneous inc/dec cancels
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         inc_v[r] = issue && id_wb_en && (id_dest == IDX_W'(r));
         dec_v[r] = wb_en && (wb_dest == IDX_W'(r)) && (cnt_q[r] != '0);
         cnt_d[r] = cnt_q[r];
         if (inc_v[r] && !dec_v[r] && (cnt_q[r] != CNT_MAX)) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (dec_v[r] && !inc_v[r]) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
      end
   end

   // Sticky error on writeback to a non-pending register; saturating stall counter
   always_comb begin
      sb_err_d    = sb_err_q || (wb_en && (cnt_q[wb_dest] == '0));
      stall_cnt_d = stall_cnt_q;
      if (hazard && !freeze && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
   end

   // Busy whenever any register has a write in flight
   always_comb begin
      busy = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         busy = busy | (cnt_q[r] != '0);
      end
   end

   // State registers; reset discards all pending state immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         sb_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         sb_err_q    <= sb_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign sb_err    = sb_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Scoreboard-based hazard controller for the decode (ID) stage. It tracks outstanding register-file writes issued from ID but not yet written back, and asserts `hazard` to stall IF/ID when a decoding instruction reads a pending register. It also owns the ID issue qualification (flush/freeze) and a stall performance counter. It sits between the ID stage, the WB stage write port and the global pipeline control (flush from branch, freeze from memory).

Parameters:
NREG, 16, number of architectural registers tracked (R0–R15).
CNT_W, 2, width of each per-register pending counter; max pending = 2^CNT_W-1.
WB_BYPASS, 1, 1 = a same-cycle writeback that retires the last pending write clears the hazard (register file writes on negedge).
STALL_W, 16, width of stall performance counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
id_valid  input  1  ID holds a valid instruction this cycle.
id_src1  input  4  first source register (Rn).
id_src1_vld  input  1  id_src1 is actually read.
id_src2  input  4  second source register (Rm, or Rd for STR).
id_src2_vld  input  1  id_src2 is actually read.
id_wb_en  input  1  decoded instruction writes id_dest.
id_dest  input  4  destination register.
flush  input  1  branch taken; ID instruction is squashed.
freeze  input  1  memory wait; whole pipeline holds.
wb_en  input  1  WB stage writes register file this cycle.
wb_dest  input  4  WB destination.
hazard  output  1  stall request to IF/ID (combinational).
issue  output  1  ID instruction advances to EXE this cycle (combinational).
busy  output  1  any counter non-zero (registered state).
sb_err  output  1  sticky: writeback to a register with zero pending.
stall_cnt  output  STALL_W  cycles in which hazard=1 and freeze=0.

Behaviour:
- State: `cnt[r]` (CNT_W bits) for r = 0..NREG-1, `sb_err`, `stall_cnt`.
- Reset (rst=0, async): all `cnt` = 0, `sb_err` = 0, `stall_cnt` = 0. Hence `busy` = 0, `hazard` = 0, `issue` = 0 while `id_valid` = 0.
- Per-source pending test: `pend(s)` = `cnt[s]` != 0.
- Bypass: if WB_BYPASS=1 and `wb_en` and `wb_dest` == s and `cnt[s]` == 1, then `pend(s)` = 0 for the hazard test only.
- Structural full: `full` = `id_wb_en` and `cnt[id_dest]` == max.
- `hazard` = `id_valid` & ~`flush` & ((`id_src1_vld` & `pend(id_src1)`) | (`id_src2_vld` & `pend(id_src2)`) | `full`).
- `issue` = `id_valid` & ~`hazard` & ~`flush` & ~`freeze`.
- Increment `inc(r)` = `issue` & `id_wb_en` & (`id_dest` == r).
- Decrement `dec(r)` = `wb_en` & (`wb_dest` == r) & (`cnt[r]` != 0).
- Counter update each rising edge:
  - inc & dec: unchanged.
  - inc only: +1.
  - dec only: −1.
  - No wrap in either direction.
- Writeback to a register with `cnt` == 0: counter stays 0; `sb_err` set to 1 and held until reset.
- `freeze` = 1: no issue, so no increments. Writebacks still decrement. `hazard` is still computed but not counted in `stall_cnt`.
- `flush` = 1: `hazard` forced 0, `issue` = 0, no increment. `flush` has priority over `hazard`.
- `stall_cnt` increments when `hazard` & ~`freeze`, and saturates at all-ones.
- Source equal to the same instruction's `id_dest` (e.g. ADD R1,R1,#1): tested against the pre-issue `cnt` only. No self-hazard.
- Reset mid-operation: all pending state is discarded immediately. Subsequent writebacks from in-flight instructions will set `sb_err`; the pipeline must be reset together.
- Latency: `hazard`/`issue` are zero-cycle (same cycle as ID inputs). The scoreboard reflects an issue from the next cycle onward.

Test Plan:
1. Reset, then MOV R0,#20 issue (`id_wb_en`=1, `id_dest`=0) -> `issue`=1. Next cycle `cnt[0]`=1, `busy`=1.
2. Back-to-back dependency: after 1, ADD R4,R0,R1 (`src1`=0) with no writeback -> `hazard`=1 each cycle and `stall_cnt` increments. `wb_en`=1, `wb_dest`=0 with WB_BYPASS=1 -> `hazard`=0 and `issue`=1 that same cycle, and `cnt[0]`=0 afterwards.
3. Three MOV R1 issues without writeback -> `cnt[1]`=3. A fourth MOV R1 -> `hazard`=1 (full). One `wb_dest`=1 -> the fourth issues, leaving `cnt[1]`=3.
4. Simultaneous issue to R2 and writeback of R2 while `cnt[2]`=1 -> `cnt[2]` stays 1, and `sb_err` stays 0.
5. Pending R3, dependent instruction in ID with `flush`=1 -> `hazard`=0, `issue`=0, `cnt` unchanged. Same instruction with `freeze`=1 -> `hazard`=1, `issue`=0, `stall_cnt` unchanged.
6. `wb_en`=1, `wb_dest`=5 with `cnt[5]`=0 -> `sb_err`=1 and held. Assert rst=0 mid-run with `busy`=1 -> `busy`, `sb_err`, `stall_cnt` = 0 immediately, before the next clock edge.
